uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Deserialises an asynchronous 8N1 line (LSB first): start bit 0, DATA_WIDTH data bits, one stop bit 1, idle-high line.
- Samples each bit at mid-bit using a CLKS_PER_BIT counter, rejects glitch starts and flags framing errors.
- Sits between the board RX pin and the byte consumer (loopback/echo logic, LEDs) on the Zybo Z7-20.

Parameters:
- CLKS_PER_BIT, 1085, sysclk cycles per bit (125 MHz / 115200 baud); must be >= 4.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- sysclk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx_en  input  1  receiver mode enable, active high.
- i_rx_serial  input  1  raw asynchronous serial line, idle high.
- o_rx_byte  output  DATA_WIDTH  last correctly framed byte; held until the next good frame.
- o_rx_dv  output  1  one-cycle pulse: o_rx_byte updated this cycle.
- o_rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- o_rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - o_rx_byte=0, o_rx_dv=0, o_rx_frame_err=0, o_rx_busy=0.
  - State=IDLE, counters=0, shift register=0.
  - Both synchroniser flops=1, so a low line at reset release is not seen as a start edge until it passes through the synchroniser.
- Synchroniser: i_rx_serial passes through 2 flops; rx_s is the 2nd-flop output, and all FSM decisions use rx_s. Pin-to-FSM latency is 2 cycles.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits.
  - bit_idx is $clog2(DATA_WIDTH) bits, with a terminal compare at DATA_WIDTH-1 (no wrap reliance).
  - H = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - busy=0, clk_cnt=0, bit_idx=0.
  - rx_s==0 -> START.
- START:
  - While clk_cnt<H, increment clk_cnt.
  - At clk_cnt==H: if rx_s==0, clk_cnt<=0 and go to DATA; else (glitch) go to IDLE with no output pulse.
- DATA:
  - While clk_cnt<CLKS_PER_BIT-1, increment clk_cnt.
  - At clk_cnt==CLKS_PER_BIT-1: clk_cnt<=0 and shift[bit_idx]<=rx_s.
  - If bit_idx==DATA_WIDTH-1 go to STOP; else bit_idx+1.
- STOP:
  - Count to CLKS_PER_BIT-1 as in DATA, then sample rx_s.
  - rx_s==1: o_rx_byte<=shift, o_rx_dv=1 next cycle, go to IDLE.
  - rx_s==0: o_rx_frame_err=1 next cycle, o_rx_byte unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Break/noise recovery: stay while rx_s==0; rx_s==1 -> IDLE.
  - Prevents a held-low line from retriggering frames.
- Pulses:
  - o_rx_dv and o_rx_frame_err are registered, exactly one cycle, mutually exclusive, never asserted back-to-back for the same frame.
- Timing (measured from the first cycle rx_s==0 seen in IDLE, cycle 0):
  - Data bit k is sampled at cycle 1+H+(k+1)*CLKS_PER_BIT.
  - The stop bit is sampled at cycle 1+H+(DATA_WIDTH+1)*CLKS_PER_BIT.
  - The dv/err pulse follows one cycle after the stop-bit sample.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start bit that directly follows the stop bit be caught; there is no dead time requirement beyond the stop bit.
- i_rx_en low (synchronous, highest priority after reset):
  - FSM to IDLE, counters cleared, no pulses.
  - o_rx_byte retained; a partial frame is discarded.
  - Synchroniser keeps running.
  - On re-enable with the line low mid-frame, the receiver may resync wrongly; frame errors are then reported normally.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- Transmitter coupling: none; i_rx_serial may be driven by uart_tx.o_tx_serial for loopback.

Test Plan (CLKS_PER_BIT=16, H=7, frames driven at exactly 16 cycles/bit):
- Drive 0xA5, stop=1, en=1 -> one o_rx_dv pulse 1+7+9*16+1=153 cycles after the start is seen at rx_s; o_rx_byte=0xA5; o_rx_frame_err stays 0; busy high throughout the frame.
- Drive line low for 4 cycles then high, then a valid 0x3C frame -> no pulse from the glitch (START returns to IDLE at clk_cnt==7); then dv with byte 0x3C.
- Drive 0xFF with stop bit=0, hold line low 3 bit times, then high, then 0x81 -> one frame_err pulse, no dv, byte stays at the prior value, FSM stays in WAIT_HIGH until the line goes high; then dv with 0x81.
- Drive 0x00 immediately followed by 0xFF (no idle gap) -> two dv pulses 160 cycles apart with bytes 0x00, 0xFF; no frame_err.
- Assert i_rst_n=0 during data bit 4 of 0x5A for 3 cycles, release with the line idle, then send 0x5A -> all outputs 0 during reset, no pulse for the broken frame; a single dv with 0x5A afterwards.
- Drop i_rx_en during data bit 2 of 0x11 (byte previously 0xA5), raise it after the line idles, send 0x22 -> no pulse for 0x11, byte holds 0xA5, busy=0 while disabled; then dv with 0x22.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, glitch rejection and framing-error reporting
module uart_rx #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  sysclk,
   input  logic                  i_rst_n,
   input  logic                  i_rx_en,
   input  logic                  i_rx_serial,
   output logic [DATA_WIDTH-1:0] o_rx_byte,
   output logic                  o_rx_dv,
   output logic                  o_rx_frame_err,
   output logic                  o_rx_busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int H  = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0] HALF_CNT = CW'(H);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   state_t                  state_q, state_d;
   logic                    sync1_q, sync1_d;
   logic                    rx_s_q, rx_s_d;
   logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]           bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   byte_q, byte_d;
   logic                    dv_q, dv_d;
   logic                    err_q, err_d;

   // Synchroniser resets high so a low pin at reset release needs two clocks to look like a start.
   always_comb begin
      sync1_d = i_rx_serial;
      rx_s_d  = sync1_q;
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      dv_d      = 1'b0;
      err_d     = 1'b0;

      if (!i_rx_en) begin
         state_d   = ST_IDLE;
         clk_cnt_d = '0;
         bit_idx_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               if (!rx_s_q) state_d = ST_START;
            end

            ST_START: begin
               if (clk_cnt_q == HALF_CNT) begin
                  clk_cnt_d = '0;
                  state_d   = rx_s_q ? ST_IDLE : ST_DATA;
               end else begin
                  clk_cnt_d = clk_cnt_q + 1'b1;
               end
            end

            ST_DATA: begin
               if (clk_cnt_q == LAST_CNT) begin
                  clk_cnt_d          = '0;
                  shift_d[bit_idx_q] = rx_s_q;
                  if (bit_idx_q == LAST_IDX) begin
                     bit_idx_d = '0;
                     state_d   = ST_STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + 1'b1;
                  end
               end else begin
                  clk_cnt_d = clk_cnt_q + 1'b1;
               end
            end

            // Leaving at mid-stop-bit lets a directly following start bit be caught.
            ST_STOP: begin
               if (clk_cnt_q == LAST_CNT) begin
                  clk_cnt_d = '0;
                  if (rx_s_q) begin
                     byte_d  = shift_q;
                     dv_d    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_WAIT_HIGH;
                  end
               end else begin
                  clk_cnt_d = clk_cnt_q + 1'b1;
               end
            end

            ST_WAIT_HIGH: begin
               if (rx_s_q) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         dv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         rx_s_q    <= rx_s_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         dv_q      <= dv_d;
         err_q     <= err_d;
      end
   end

   assign o_rx_byte      = byte_q;
   assign o_rx_dv        = dv_q;
   assign o_rx_frame_err = err_q;
   assign o_rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DW  = 8;

   logic          sysclk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_rx_en = 1'b1;
   logic          i_rx_serial = 1'b1;
   logic [DW-1:0] o_rx_byte;
   logic          o_rx_dv;
   logic          o_rx_frame_err;
   logic          o_rx_busy;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
      .sysclk         (sysclk),
      .i_rst_n        (i_rst_n),
      .i_rx_en        (i_rx_en),
      .i_rx_serial    (i_rx_serial),
      .o_rx_byte      (o_rx_byte),
      .o_rx_dv        (o_rx_dv),
      .o_rx_frame_err (o_rx_frame_err),
      .o_rx_busy      (o_rx_busy)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   int         dv_cyc[$];
   int         err_seen = 0;
   bit         busy_watch = 1'b0;
   int         busy_drop = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_dv;
      logic [7:0] exp_byte;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every dv pops one expected byte; dv with nothing pending is an error.
   always @(negedge sysclk) begin
      if (i_rst_n) begin
         if (o_rx_dv) begin
            dv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_dv: got byte %0h, expected no pulse", o_rx_byte);
            end else begin
               check("rx_byte", {24'd0, o_rx_byte}, {24'd0, exp_q.pop_front()});
            end
         end
         if (o_rx_frame_err) err_seen++;
         if (o_rx_dv && o_rx_frame_err) check("dv_err_exclusive", 32'd1, 32'd0);
         if (busy_watch && !o_rx_busy) busy_drop++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      i_rx_serial = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < DW; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      vec_t       tbl[6];
      int         s;
      int         e0;
      int         n0;
      logic [7:0] d;

      tbl[0] = '{8'hC3, 1'b1, 1'b1, 8'hC3};
      tbl[1] = '{8'h7E, 1'b0, 1'b0, 8'hC3};
      tbl[2] = '{8'h01, 1'b1, 1'b1, 8'h01};
      tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80};
      tbl[4] = '{8'hFF, 1'b0, 1'b0, 8'h80};
      tbl[5] = '{8'h55, 1'b1, 1'b1, 8'h55};

      tick(3);
      check("reset_byte", {24'd0, o_rx_byte}, 32'd0);
      check("reset_dv", {31'd0, o_rx_dv}, 32'd0);
      check("reset_err", {31'd0, o_rx_frame_err}, 32'd0);
      check("reset_busy", {31'd0, o_rx_busy}, 32'd0);
      i_rst_n = 1'b1;
      tick(4);

      // Basic frame with latency and busy coverage
      dv_cyc.delete();
      exp_q.push_back(8'hA5);
      d = 8'hA5;
      s = cyc;
      drive_bit(1'b0);
      busy_watch = 1'b1;
      for (int i = 0; i < DW; i++) drive_bit(d[i]);
      busy_watch = 1'b0;
      drive_bit(1'b1);
      wait_drain("a5_drain");
      check("a5_dv_count", dv_cyc.size(), 1);
      if (dv_cyc.size() >= 1) check("a5_latency", dv_cyc[0] - s, 155);
      check("a5_err", err_seen, 0);
      check("a5_busy_drop", busy_drop, 0);
      tick(2 * CPB);
      check("a5_idle_busy", {31'd0, o_rx_busy}, 32'd0);

      // Glitch start rejected, then a valid frame
      n0 = dv_cyc.size();
      i_rx_serial = 1'b0;
      tick(4);
      i_rx_serial = 1'b1;
      tick(2 * CPB);
      check("glitch_busy", {31'd0, o_rx_busy}, 32'd0);
      check("glitch_no_dv", dv_cyc.size(), n0);
      check("glitch_byte", {24'd0, o_rx_byte}, 32'hA5);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_drain("3c_drain");
      tick(2 * CPB);

      // Framing error followed by a held-low line
      e0 = err_seen;
      n0 = dv_cyc.size();
      send_frame(8'hFF, 1'b0);
      tick(3 * CPB);
      check("ferr_count", err_seen - e0, 1);
      check("ferr_no_dv", dv_cyc.size(), n0);
      check("ferr_wait_busy", {31'd0, o_rx_busy}, 32'd1);
      check("ferr_byte_held", {24'd0, o_rx_byte}, 32'h3C);
      i_rx_serial = 1'b1;
      tick(CPB);
      check("ferr_recover_busy", {31'd0, o_rx_busy}, 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      wait_drain("81_drain");
      tick(2 * CPB);

      // Back-to-back frames, no idle gap
      dv_cyc.delete();
      e0 = err_seen;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_drain("b2b_drain");
      check("b2b_dv_count", dv_cyc.size(), 2);
      if (dv_cyc.size() >= 2) check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 160);
      check("b2b_err", err_seen - e0, 0);
      tick(2 * CPB);

      // Reset during data bit 4
      d = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      i_rx_serial = d[4];
      tick(5);
      i_rst_n = 1'b0;
      i_rx_serial = 1'b1;
      #1;
      check("rst_byte", {24'd0, o_rx_byte}, 32'd0);
      check("rst_dv", {31'd0, o_rx_dv}, 32'd0);
      check("rst_err", {31'd0, o_rx_frame_err}, 32'd0);
      check("rst_busy", {31'd0, o_rx_busy}, 32'd0);
      tick(3);
      i_rst_n = 1'b1;
      tick(2 * CPB);
      check("rst_after_busy", {31'd0, o_rx_busy}, 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_drain("5a_drain");
      tick(2 * CPB);

      // Enable dropped mid-frame
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      wait_drain("en_pre_drain");
      tick(CPB);
      n0 = dv_cyc.size();
      e0 = err_seen;
      d = 8'h11;
      drive_bit(1'b0);
      drive_bit(d[0]);
      drive_bit(d[1]);
      i_rx_serial = d[2];
      tick(8);
      i_rx_en = 1'b0;
      tick(8);
      for (int i = 3; i < DW; i++) drive_bit(d[i]);
      drive_bit(1'b1);
      tick(CPB);
      check("en_off_busy", {31'd0, o_rx_busy}, 32'd0);
      check("en_off_byte", {24'd0, o_rx_byte}, 32'hA5);
      check("en_off_no_dv", dv_cyc.size(), n0);
      check("en_off_no_err", err_seen - e0, 0);
      i_rx_en = 1'b1;
      tick(CPB);
      exp_q.push_back(8'h22);
      send_frame(8'h22, 1'b1);
      wait_drain("22_drain");
      tick(2 * CPB);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         e0 = err_seen;
         if (tbl[v].exp_dv) exp_q.push_back(tbl[v].data);
         send_frame(tbl[v].data, tbl[v].stop);
         i_rx_serial = 1'b1;
         tick(2 * CPB);
         wait_drain($sformatf("tbl%0d_drain", v));
         check($sformatf("tbl%0d_byte", v), {24'd0, o_rx_byte}, {24'd0, tbl[v].exp_byte});
         check($sformatf("tbl%0d_err", v), err_seen - e0, {31'd0, ~tbl[v].stop});
         check($sformatf("tbl%0d_busy", v), {31'd0, o_rx_busy}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
